// File: rtl/qspi_flash_resp_if.sv
// qspi_flash_resp_if
//   Bus bundle between the XIP read controller / backing memory and the
//   QSPI flash responder.
//   Signals:
//     sclk_in, cs_n_in, io_in  : QSPI lines driven by the controller
//     io_out, io_oe_out        : responder-driven io[3:0] and per-line enables
//     mem_rd_en_out            : one-cycle backing-memory read strobe
//     mem_addr_out             : byte address for that read (MEM_AW bits)
//     mem_rdata_in             : read byte, valid one h_clk after the strobe
//   Modports:
//     slave  : the responder
//     master : the controller plus the backing memory
interface qspi_flash_resp_if #(
  parameter int MEM_AW = 24
) ();
  logic              sclk_in;
  logic              cs_n_in;
  logic [3:0]        io_in;
  logic [3:0]        io_out;
  logic [3:0]        io_oe_out;
  logic              mem_rd_en_out;
  logic [MEM_AW-1:0] mem_addr_out;
  logic [7:0]        mem_rdata_in;

  modport slave (
    input  sclk_in, cs_n_in, io_in, mem_rdata_in,
    output io_out, io_oe_out, mem_rd_en_out, mem_addr_out
  );

  modport master (
    output sclk_in, cs_n_in, io_in, mem_rdata_in,
    input  io_out, io_oe_out, mem_rd_en_out, mem_addr_out
  );
endinterface

// File: rtl/qspi_flash_resp.sv
// qspi_flash_resp
//   QSPI flash responder (SPI mode 0). Oversamples sclk/cs_n/io on h_clk,
//   decodes 0x03 (single read), 0xEB (quad I/O read) and 0xB7 (enter 4-byte
//   address mode), and streams bytes from a byte-wide backing memory with a
//   one-byte prefetch so the next byte is always on hand at a byte boundary.
//   Ports:
//     h_clk            : system clock, at least 4x the sclk frequency
//     h_rstn           : asynchronous active-low reset
//     bus              : qspi_flash_resp_if.slave (QSPI lines + memory port)
//     addr_4b_mode_out : sticky 4-byte address mode flag
//     busy_out         : high whenever the responder is not idle
//   Optional (macro QSPI_RESP_ILLEGAL_CMD_FLAG_EN):
//     err_clr_in       : clears err_cmd_out
//     err_cmd_out      : set when an unknown command is decoded
module qspi_flash_resp #(
  parameter int MEM_AW      = 24,
  parameter int DUMMY_CYC   = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             h_clk,
  input  logic             h_rstn,
  qspi_flash_resp_if.slave bus,
  output logic             addr_4b_mode_out,
  output logic             busy_out
`ifdef QSPI_RESP_ILLEGAL_CMD_FLAG_EN
  ,
  input  logic             err_clr_in,
  output logic             err_cmd_out
`endif
);

  localparam int DCW = (DUMMY_CYC > 1) ? $clog2(DUMMY_CYC) : 1;
  localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [3:0]             io_sync_r [SYNC_STAGES];
  logic                   sclk_prev_r;

  state_t            state_r;
  logic [5:0]        bit_cnt_r;
  logic [DCW-1:0]    dummy_cnt_r;
  logic [2:0]        data_cnt_r;
  logic [6:0]        cmd_sr_r;
  logic              quad_r;
  logic [MEM_AW-1:0] addr_r;
  logic [7:0]        data_sr_r;
  logic [7:0]        byte_buf_r;
  logic              rd_dly_r;

  logic              sclk_s;
  logic              cs_s;
  logic [3:0]        io_s;
  logic              rise_s;
  logic              fall_s;
  logic [7:0]        cmd_next_s;
  logic [MEM_AW-1:0] addr_shift_s;
  logic [5:0]        addr_last_s;
  logic [7:0]        byte_next_s;
  logic              byte_last_s;

  assign sclk_s  = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s    = cs_sync_r[SYNC_STAGES-1];
  assign io_s    = io_sync_r[SYNC_STAGES-1];
  assign rise_s  = sclk_s & ~sclk_prev_r;
  assign fall_s  = ~sclk_s & sclk_prev_r;

  assign cmd_next_s = {cmd_sr_r, io_s[0]};

  // Shifting into an MEM_AW-wide register drops the high address bits, which
  // is exactly the truncation wanted for 24- and 32-bit addresses alike.
  assign addr_shift_s = quad_r ? {addr_r[MEM_AW-5:0], io_s}
                               : {addr_r[MEM_AW-2:0], io_s[0]};
  assign addr_last_s  = quad_r ? (addr_4b_mode_out ? 6'd7  : 6'd5)
                               : (addr_4b_mode_out ? 6'd31 : 6'd23);

  // The byte returned for a strobe may land in the same cycle the fall is
  // seen; take it straight from the memory bus in that case.
  assign byte_next_s = rd_dly_r ? bus.mem_rdata_in : byte_buf_r;
  assign byte_last_s = quad_r ? (data_cnt_r == 3'd1) : (data_cnt_r == 3'd7);

`ifdef QSPI_RESP_ILLEGAL_CMD_FLAG_EN
  logic illegal_cmd_s;
  assign illegal_cmd_s = (state_r == ST_CMD) && !cs_s && rise_s &&
                         (bit_cnt_r == 6'd7) &&
                         (cmd_next_s != 8'h03) && (cmd_next_s != 8'hEB) &&
                         (cmd_next_s != 8'hB7);
`endif

  // Input synchronizers and previous-sclk tracking for edge detection.
  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      for (int i = 0; i < SYNC_STAGES; i++) begin
        io_sync_r[i] <= 4'h0;
      end
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r[0] <= bus.sclk_in;
      cs_sync_r[0]   <= bus.cs_n_in;
      io_sync_r[0]   <= bus.io_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_r[i] <= sclk_sync_r[i-1];
        cs_sync_r[i]   <= cs_sync_r[i-1];
        io_sync_r[i]   <= io_sync_r[i-1];
      end
      sclk_prev_r <= sclk_s;
    end
  end

  // Protocol FSM with registered bus, memory and status outputs.
  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      state_r           <= ST_IDLE;
      bit_cnt_r         <= 6'd0;
      dummy_cnt_r       <= {DCW{1'b0}};
      data_cnt_r        <= 3'd0;
      cmd_sr_r          <= 7'd0;
      quad_r            <= 1'b0;
      addr_r            <= {MEM_AW{1'b0}};
      data_sr_r         <= 8'h00;
      byte_buf_r        <= 8'h00;
      rd_dly_r          <= 1'b0;
      bus.io_out        <= 4'h0;
      bus.io_oe_out     <= 4'h0;
      bus.mem_rd_en_out <= 1'b0;
      bus.mem_addr_out  <= {MEM_AW{1'b0}};
      addr_4b_mode_out  <= 1'b0;
      busy_out          <= 1'b0;
    end else begin
      bus.mem_rd_en_out <= 1'b0;
      if (cs_s) begin
        // Deselect: abandon whatever was in progress, including a fetch.
        state_r       <= ST_IDLE;
        bit_cnt_r     <= 6'd0;
        dummy_cnt_r   <= {DCW{1'b0}};
        data_cnt_r    <= 3'd0;
        rd_dly_r      <= 1'b0;
        byte_buf_r    <= 8'h00;
        bus.io_out    <= 4'h0;
        bus.io_oe_out <= 4'h0;
        busy_out      <= 1'b0;
      end else begin
        busy_out <= 1'b1;
        rd_dly_r <= bus.mem_rd_en_out;
        if (rd_dly_r) begin
          byte_buf_r <= bus.mem_rdata_in;
        end
        case (state_r)
          ST_IDLE: begin
            state_r   <= ST_CMD;
            bit_cnt_r <= 6'd0;
          end
          ST_CMD: begin
            if (rise_s) begin
              cmd_sr_r  <= cmd_next_s[6:0];
              bit_cnt_r <= bit_cnt_r + 6'd1;
              if (bit_cnt_r == 6'd7) begin
                bit_cnt_r <= 6'd0;
                addr_r    <= {MEM_AW{1'b0}};
                case (cmd_next_s)
                  8'h03: begin
                    quad_r  <= 1'b0;
                    state_r <= ST_ADDR;
                  end
                  8'hEB: begin
                    quad_r  <= 1'b1;
                    state_r <= ST_ADDR;
                  end
                  8'hB7: begin
                    addr_4b_mode_out <= 1'b1;
                    state_r          <= ST_IGNORE;
                  end
                  default: begin
                    state_r <= ST_IGNORE;
                  end
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (rise_s) begin
              addr_r    <= addr_shift_s;
              bit_cnt_r <= bit_cnt_r + 6'd1;
              if (bit_cnt_r == addr_last_s) begin
                bit_cnt_r         <= 6'd0;
                bus.mem_rd_en_out <= 1'b1;
                bus.mem_addr_out  <= addr_shift_s;
                data_cnt_r        <= 3'd0;
                dummy_cnt_r       <= {DCW{1'b0}};
                state_r           <= quad_r ? ST_DUMMY : ST_DATA;
              end
            end
          end
          ST_DUMMY: begin
            if (rise_s) begin
              dummy_cnt_r <= dummy_cnt_r + {{(DCW-1){1'b0}}, 1'b1};
              if (dummy_cnt_r == DCW'(DUMMY_CYC - 1)) begin
                dummy_cnt_r <= {DCW{1'b0}};
                state_r     <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (fall_s) begin
              if (data_cnt_r == 3'd0) begin
                // Byte boundary: load the held byte and prefetch the next one.
                if (quad_r) begin
                  bus.io_out    <= byte_next_s[7:4];
                  data_sr_r     <= {byte_next_s[3:0], 4'h0};
                  bus.io_oe_out <= 4'b1111;
                end else begin
                  bus.io_out    <= {2'b00, byte_next_s[7], 1'b0};
                  data_sr_r     <= {byte_next_s[6:0], 1'b0};
                  bus.io_oe_out <= 4'b0010;
                end
                bus.mem_rd_en_out <= 1'b1;
                bus.mem_addr_out  <= bus.mem_addr_out + ADDR_ONE;
              end else begin
                if (quad_r) begin
                  bus.io_out <= data_sr_r[7:4];
                  data_sr_r  <= {data_sr_r[3:0], 4'h0};
                end else begin
                  bus.io_out <= {2'b00, data_sr_r[7], 1'b0};
                  data_sr_r  <= {data_sr_r[6:0], 1'b0};
                end
              end
              data_cnt_r <= byte_last_s ? 3'd0 : (data_cnt_r + 3'd1);
            end
          end
          ST_IGNORE: begin
            bus.io_oe_out <= 4'h0;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef QSPI_RESP_ILLEGAL_CMD_FLAG_EN
  // Sticky unknown-command flag; a new set wins over a same-cycle clear.
  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      err_cmd_out <= 1'b0;
    end else if (illegal_cmd_s) begin
      err_cmd_out <= 1'b1;
    end else if (err_clr_in) begin
      err_cmd_out <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_qspi_flash_resp.sv
// Self-checking bench for qspi_flash_resp: a mode-0 QSPI controller model,
// a byte memory, and an expected-data model of mem[(A+i) mod 2^24].
module tb_qspi_flash_resp;
  localparam int MEM_AW      = 24;
  localparam int DUMMY_CYC   = 6;
  localparam int SYNC_STAGES = 2;
  localparam int H           = 4;  // h_clk cycles per sclk half period

  logic h_clk = 1'b0;
  logic h_rstn = 1'b0;
  logic addr_4b_mode_out;
  logic busy_out;
`ifdef QSPI_RESP_ILLEGAL_CMD_FLAG_EN
  logic err_clr_in = 1'b0;
  logic err_cmd_out;
`endif

  qspi_flash_resp_if #(.MEM_AW(MEM_AW)) bus ();

  qspi_flash_resp #(
    .MEM_AW(MEM_AW), .DUMMY_CYC(DUMMY_CYC), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .h_clk(h_clk),
    .h_rstn(h_rstn),
    .bus(bus),
    .addr_4b_mode_out(addr_4b_mode_out),
    .busy_out(busy_out)
`ifdef QSPI_RESP_ILLEGAL_CMD_FLAG_EN
    , .err_clr_in(err_clr_in)
    , .err_cmd_out(err_cmd_out)
`endif
  );

  always #5 h_clk = ~h_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_4b  = 1'b0;
  logic [7:0]  mem_ovr [logic [23:0]];
  logic [23:0] strobe_q [$];
  logic [7:0]  got_q [$];
  bit          pre_oe_bad;
  bit          data_oe_bad;
  logic [3:0]  smp_d, oe_d;

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Backing memory (one-cycle read latency) and strobe recorder.
  always @(posedge h_clk) begin
    if (bus.mem_rd_en_out === 1'b1) begin
      bus.mem_rdata_in <= mem_val(bus.mem_addr_out);
      strobe_q.push_back(bus.mem_addr_out);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge h_clk);
  endtask

  // One sclk period: drive io while low, sample responder just before the rise.
  task automatic sclk_cycle(input logic [3:0] drv, output logic [3:0] smp, output logic [3:0] oe);
    bus.io_in = drv;
    wait_clk(H);
    smp = bus.io_out;
    oe  = bus.io_oe_out;
    bus.sclk_in = 1'b1;
    wait_clk(H);
    bus.sclk_in = 1'b0;
  endtask

  task automatic frame_start();
    bus.cs_n_in = 1'b0;
    wait_clk(H);
  endtask

  task automatic frame_end();
    wait_clk(H);
    bus.cs_n_in = 1'b1;
    wait_clk(2 * H);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk_cycle({3'b000, v[i]}, smp_d, oe_d);
      if (oe_d !== 4'h0) pre_oe_bad = 1'b1;
    end
  endtask

  task automatic send_nibbles(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk_cycle(v[4*i +: 4], smp_d, oe_d);
      if (oe_d !== 4'h0) pre_oe_bad = 1'b1;
    end
  endtask

  // Full read frame; collects received bytes into got_q.
  task automatic do_read(input bit quad, input logic [31:0] addr, input int nbytes);
    logic [7:0] by;
    got_q.delete();
    strobe_q.delete();
    pre_oe_bad  = 1'b0;
    data_oe_bad = 1'b0;
    frame_start();
    send_bits(quad ? 32'hEB : 32'h03, 8);
    if (quad) send_nibbles(addr, exp_4b ? 8 : 6);
    else      send_bits(addr, exp_4b ? 32 : 24);
    if (quad) begin
      for (int d = 0; d < DUMMY_CYC; d++) begin
        sclk_cycle(4'($urandom), smp_d, oe_d);
        if (oe_d !== 4'h0) pre_oe_bad = 1'b1;
      end
    end
    for (int b = 0; b < nbytes; b++) begin
      by = 8'h00;
      for (int k = 0; k < (quad ? 2 : 8); k++) begin
        sclk_cycle(4'h0, smp_d, oe_d);
        if (oe_d !== (quad ? 4'hF : 4'h2)) data_oe_bad = 1'b1;
        by = quad ? {by[3:0], smp_d} : {by[6:0], smp_d[1]};
      end
      got_q.push_back(by);
    end
    frame_end();
  endtask

  task automatic test_reset();
    wait_clk(3);
    n_tests++; if (bus.io_oe_out !== 4'h0) begin n_fail++; $display("FAIL rst_oe got %h exp 0", bus.io_oe_out); end
    n_tests++; if (bus.io_out !== 4'h0) begin n_fail++; $display("FAIL rst_io got %h exp 0", bus.io_out); end
    n_tests++; if (bus.mem_rd_en_out !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en got %b exp 0", bus.mem_rd_en_out); end
    n_tests++; if (bus.mem_addr_out !== 24'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", bus.mem_addr_out); end
    n_tests++; if (addr_4b_mode_out !== 1'b0) begin n_fail++; $display("FAIL rst_4b got %b exp 0", addr_4b_mode_out); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy_out); end
`ifdef QSPI_RESP_ILLEGAL_CMD_FLAG_EN
    n_tests++; if (err_cmd_out !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err_cmd_out); end
`endif
    h_rstn = 1'b1;
    wait_clk(2 * H);
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy_out); end
  endtask

  task automatic test_single_read();
    logic [7:0]  exp_b [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic [31:0] a;
    int          n;
    mem_ovr[24'h10] = 8'hA5; mem_ovr[24'h11] = 8'h3C;
    mem_ovr[24'h12] = 8'hFF; mem_ovr[24'h13] = 8'h00;
    do_read(1'b0, 32'h10, 4);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (got_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL single_byte%0d got %h exp %h", i, got_q[i], exp_b[i]); end
    end
    n_tests++; if (pre_oe_bad) begin n_fail++; $display("FAIL single_pre_oe got driven exp 0000"); end
    n_tests++; if (data_oe_bad) begin n_fail++; $display("FAIL single_data_oe got wrong exp 0010"); end
    n_tests++; if (strobe_q.size() != 6) begin n_fail++; $display("FAIL single_strobes got %0d exp 6", strobe_q.size()); end
    for (int r = 0; r < 3; r++) begin
      a = {8'h00, 24'($urandom)};
      n = $urandom_range(1, 3);
      do_read(1'b0, a, n);
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (got_q[i] !== mem_val(a[23:0] + 24'(i))) begin
          n_fail++; $display("FAIL rand_single a=%h byte%0d got %h exp %h", a, i, got_q[i], mem_val(a[23:0] + 24'(i)));
        end
      end
      n_tests++;
      if (strobe_q.size() != n + 2) begin
        n_fail++; $display("FAIL rand_single_strobes got %0d exp %0d", strobe_q.size(), n + 2);
      end else begin
        for (int j = 0; j < n + 2; j++) begin
          n_tests++;
          if (strobe_q[j] !== a[23:0] + 24'(j)) begin
            n_fail++; $display("FAIL rand_single_saddr%0d got %h exp %h", j, strobe_q[j], a[23:0] + 24'(j));
          end
        end
      end
    end
  endtask

  task automatic test_quad_read();
    logic [31:0] a;
    mem_ovr[24'h100] = 8'h9E;
    for (int i = 1; i < 8; i++) mem_ovr[24'h100 + 24'(i)] = 8'($urandom);
    for (int r = 0; r < 3; r++) begin
      a = (r == 0) ? 32'h100 : {8'h00, 24'($urandom)};
      do_read(1'b1, a, 8);
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if (got_q[i] !== mem_val(a[23:0] + 24'(i))) begin
          n_fail++; $display("FAIL quad a=%h byte%0d got %h exp %h", a, i, got_q[i], mem_val(a[23:0] + 24'(i)));
        end
      end
      n_tests++; if (pre_oe_bad) begin n_fail++; $display("FAIL quad_pre_oe got driven exp 0000"); end
      n_tests++; if (data_oe_bad) begin n_fail++; $display("FAIL quad_data_oe got wrong exp 1111"); end
      n_tests++;
      if (strobe_q.size() != 10) begin
        n_fail++; $display("FAIL quad_strobes got %0d exp 10", strobe_q.size());
      end else begin
        n_tests++;
        if (strobe_q[9] !== a[23:0] + 24'd9) begin
          n_fail++; $display("FAIL quad_last_saddr got %h exp %h", strobe_q[9], a[23:0] + 24'd9);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_read(1'b0, 32'hFFFFFF, 2);
    n_tests++; if (strobe_q.size() < 2 || strobe_q[1] !== 24'h000000) begin n_fail++; $display("FAIL wrap_saddr got %h exp 000000", (strobe_q.size() < 2) ? 24'hxxxxxx : strobe_q[1]); end
    n_tests++; if (got_q[0] !== mem_val(24'hFFFFFF)) begin n_fail++; $display("FAIL wrap_b0 got %h exp %h", got_q[0], mem_val(24'hFFFFFF)); end
    n_tests++; if (got_q[1] !== mem_val(24'h000000)) begin n_fail++; $display("FAIL wrap_b1 got %h exp %h", got_q[1], mem_val(24'h000000)); end
  endtask

  task automatic test_abort();
    strobe_q.delete();
    pre_oe_bad = 1'b0;
    frame_start();
    send_bits(32'hEB, 8);
    send_nibbles(32'h123, 3);
    bus.cs_n_in = 1'b1;
    wait_clk(2 * H);
    n_tests++; if (strobe_q.size() != 0) begin n_fail++; $display("FAIL abort_addr_strobes got %0d exp 0", strobe_q.size()); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL abort_addr_busy got %b exp 0", busy_out); end
    // Abort in the middle of a data byte.
    frame_start();
    send_bits(32'h03, 8);
    send_bits(32'h40, 24);
    for (int k = 0; k < 12; k++) sclk_cycle(4'h0, smp_d, oe_d);
    wait_clk(H);
    bus.cs_n_in = 1'b1;
    wait_clk(SYNC_STAGES);
    n_tests++; if (bus.io_oe_out !== 4'b0010) begin n_fail++; $display("FAIL abort_oe_pre got %b exp 0010", bus.io_oe_out); end
    wait_clk(1);
    n_tests++; if (bus.io_oe_out !== 4'h0) begin n_fail++; $display("FAIL abort_oe_off got %b exp 0000", bus.io_oe_out); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy_out); end
    wait_clk(2 * H);
    do_read(1'b0, 32'h4, 1);
    n_tests++; if (got_q[0] !== mem_val(24'h4)) begin n_fail++; $display("FAIL abort_reread got %h exp %h", got_q[0], mem_val(24'h4)); end
    n_tests++; if (strobe_q.size() != 3) begin n_fail++; $display("FAIL abort_reread_strobes got %0d exp 3", strobe_q.size()); end
  endtask

  task automatic test_4b_mode();
    logic [31:0] a;
    pre_oe_bad = 1'b0;
    frame_start();
    send_bits(32'hB7, 8);
    wait_clk(H);
    n_tests++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL b7_busy got %b exp 1", busy_out); end
    frame_end();
    n_tests++; if (addr_4b_mode_out !== 1'b1) begin n_fail++; $display("FAIL b7_flag got %b exp 1", addr_4b_mode_out); end
    n_tests++; if (pre_oe_bad) begin n_fail++; $display("FAIL b7_oe got driven exp 0000"); end
    exp_4b = 1'b1;
    mem_ovr[24'h20] = 8'($urandom);
    do_read(1'b1, 32'h01000020, 2);
    n_tests++; if (strobe_q.size() < 1 || strobe_q[0] !== 24'h000020) begin n_fail++; $display("FAIL 4b_saddr got %h exp 000020", (strobe_q.size() < 1) ? 24'hxxxxxx : strobe_q[0]); end
    n_tests++; if (got_q[0] !== mem_val(24'h20)) begin n_fail++; $display("FAIL 4b_b0 got %h exp %h", got_q[0], mem_val(24'h20)); end
    n_tests++; if (got_q[1] !== mem_val(24'h21)) begin n_fail++; $display("FAIL 4b_b1 got %h exp %h", got_q[1], mem_val(24'h21)); end
    n_tests++; if (strobe_q.size() != 4) begin n_fail++; $display("FAIL 4b_strobes got %0d exp 4", strobe_q.size()); end
    a = $urandom;
    do_read(1'b0, a, 2);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (got_q[i] !== mem_val(a[23:0] + 24'(i))) begin
        n_fail++; $display("FAIL 4b_single a=%h byte%0d got %h exp %h", a, i, got_q[i], mem_val(a[23:0] + 24'(i)));
      end
    end
  endtask

  task automatic test_illegal_cmd();
    logic [7:0] c;
    do c = 8'($urandom); while (c == 8'h03 || c == 8'hEB || c == 8'hB7);
    strobe_q.delete();
    pre_oe_bad = 1'b0;
    frame_start();
    send_bits({24'h0, c}, 8);
    send_bits($urandom, 16);
    n_tests++; if (pre_oe_bad) begin n_fail++; $display("FAIL illegal_oe cmd=%h got driven exp 0000", c); end
    n_tests++; if (strobe_q.size() != 0) begin n_fail++; $display("FAIL illegal_strobes got %0d exp 0", strobe_q.size()); end
    n_tests++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL illegal_busy got %b exp 1", busy_out); end
`ifdef QSPI_RESP_ILLEGAL_CMD_FLAG_EN
    n_tests++; if (err_cmd_out !== 1'b1) begin n_fail++; $display("FAIL err_set cmd=%h got %b exp 1", c, err_cmd_out); end
    frame_end();
    n_tests++; if (err_cmd_out !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err_cmd_out); end
    err_clr_in = 1'b1;
    wait_clk(1);
    err_clr_in = 1'b0;
    wait_clk(1);
    n_tests++; if (err_cmd_out !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b exp 0", err_cmd_out); end
`else
    frame_end();
`endif
  endtask

  task automatic test_reset_mid_data();
    frame_start();
    send_bits(32'h03, 8);
    send_bits(32'h00ABCDE0, 32);
    for (int k = 0; k < 5; k++) sclk_cycle(4'h0, smp_d, oe_d);
    n_tests++; if (bus.io_oe_out !== 4'b0010) begin n_fail++; $display("FAIL mid_oe got %b exp 0010", bus.io_oe_out); end
    #3;
    h_rstn = 1'b0;
    #1;
    n_tests++; if (bus.io_oe_out !== 4'h0) begin n_fail++; $display("FAIL arst_oe got %b exp 0000", bus.io_oe_out); end
    n_tests++; if (bus.io_out !== 4'h0) begin n_fail++; $display("FAIL arst_io got %h exp 0", bus.io_out); end
    n_tests++; if (bus.mem_addr_out !== 24'h0) begin n_fail++; $display("FAIL arst_addr got %h exp 0", bus.mem_addr_out); end
    n_tests++; if (bus.mem_rd_en_out !== 1'b0) begin n_fail++; $display("FAIL arst_rd_en got %b exp 0", bus.mem_rd_en_out); end
    n_tests++; if (addr_4b_mode_out !== 1'b0) begin n_fail++; $display("FAIL arst_4b got %b exp 0", addr_4b_mode_out); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", busy_out); end
    bus.cs_n_in = 1'b1;
    wait_clk(2);
    h_rstn = 1'b1;
    exp_4b = 1'b0;
    wait_clk(2 * H);
  endtask

  initial begin
    bus.sclk_in      = 1'b0;
    bus.cs_n_in      = 1'b1;
    bus.io_in        = 4'h0;
    bus.mem_rdata_in = 8'h00;
    test_reset();
    test_single_read();
    test_quad_read();
    test_wrap();
    test_abort();
    test_4b_mode();
    test_illegal_cmd();
    test_reset_mid_data();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
